// File: rtl/vm_pkg.sv
// Shared types and helpers for the multi-candidate voting machine.
// Optional feature macro used by the top level: VM_TOTAL_VOTES_EN.
package vm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OPEN  = 2'd1,
    TALLY = 2'd2,
    DONE  = 2'd3
  } poll_state_t;

  // ceil(log2(n)), but never less than 1 so a candidate index always has a bit
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/multi_candidate_voting_machine_if.sv
// Vote entry handshake between the ballot front end (master) and the counter (slave).
interface multi_candidate_voting_machine_if #(
  parameter int unsigned SEL_W = 2
);
  logic             vote_valid;
  logic [SEL_W-1:0] vote_sel;
  logic             vote_ready;
  logic             vote_reject;

  modport master (output vote_valid, vote_sel, input vote_ready, vote_reject);
  modport slave  (input vote_valid, vote_sel, output vote_ready, vote_reject);
endinterface

// File: rtl/vm_tally_scan.sv
// Sequential max/tie scanner: walks one candidate per cycle after start.
// done is high during the cycle the last candidate is examined, so the
// final winner/tie are registered on the same edge the caller sees done.
module vm_tally_scan #(
  parameter int unsigned NUM_CAND = 4,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [NUM_CAND*CNT_W-1:0] counts,
  output logic [SEL_W-1:0]          winner,
  output logic                      tie,
  output logic                      done
);

  logic             busy;
  logic [SEL_W-1:0] idx;
  logic [CNT_W-1:0] max_cnt;
  logic [CNT_W-1:0] cur;

  // Select the counter currently under examination
  always_comb begin
    cur = '0;
    for (int unsigned i = 0; i < NUM_CAND; i++) begin
      if (idx == SEL_W'(i)) cur = counts[i*CNT_W +: CNT_W];
    end
  end

  assign done = busy && (idx == SEL_W'(NUM_CAND - 1));

  // Scan state: strict-greater updates keep the lowest index on equal counts;
  // a later strict max clears any tie seen against an earlier, smaller max
  always_ff @(posedge clk) begin
    if (reset) begin
      busy    <= 1'b0;
      idx     <= '0;
      max_cnt <= '0;
      winner  <= '0;
      tie     <= 1'b0;
    end else if (start) begin
      busy <= 1'b1;
      idx  <= '0;
    end else if (busy) begin
      if (idx == '0) begin
        max_cnt <= cur;
        winner  <= '0;
        tie     <= 1'b0;
      end else if (cur > max_cnt) begin
        max_cnt <= cur;
        winner  <= idx;
        tie     <= 1'b0;
      end else if (cur == max_cnt) begin
        tie <= 1'b1;
      end
      if (done) busy <= 1'b0;
      else      idx  <= idx + 1'b1;
    end
  end

endmodule

// File: rtl/multi_candidate_voting_machine.sv
// Multi-candidate vote counter with poll life-cycle FSM and saturating counters.
// Optional: define VM_TOTAL_VOTES_EN to add the total_votes output.
// The vote interface instance must be built with SEL_W = clog2_min1(NUM_CAND).
module multi_candidate_voting_machine
  import vm_pkg::*;
#(
  parameter int unsigned NUM_CAND = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  open_poll,
  input  logic                                  close_poll,
  multi_candidate_voting_machine_if.slave       vote,
  output logic [NUM_CAND*CNT_W-1:0]             counts,
  output logic [1:0]                            poll_state,
  output logic [clog2_min1(NUM_CAND)-1:0]       winner,
  output logic                                  winner_valid,
  output logic                                  tie
`ifdef VM_TOTAL_VOTES_EN
  ,
  output logic [CNT_W+clog2_min1(NUM_CAND)-1:0] total_votes
`endif
);

  localparam int unsigned SEL_W = clog2_min1(NUM_CAND);

  poll_state_t      state;
  logic [CNT_W-1:0] cnt [NUM_CAND];
  logic             in_range;
  logic             accept;
  logic             reject;
  logic             scan_start;
  logic             scan_done;

  assign in_range        = 32'(vote.vote_sel) < NUM_CAND;
  assign accept          = vote.vote_valid && (state == OPEN) && in_range;
  assign vote.vote_ready = (state == OPEN);
  assign vote.vote_reject = reject;
  assign poll_state      = state;
  assign scan_start      = (state == OPEN) && close_poll;

  // Flatten the counter array onto the counts bus
  always_comb begin
    counts = '0;
    for (int unsigned i = 0; i < NUM_CAND; i++) begin
      counts[i*CNT_W +: CNT_W] = cnt[i];
    end
  end

  // Poll FSM, vote counters and registered status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      winner_valid <= 1'b0;
      reject       <= 1'b0;
      for (int unsigned i = 0; i < NUM_CAND; i++) cnt[i] <= '0;
`ifdef VM_TOTAL_VOTES_EN
      total_votes  <= '0;
`endif
    end else begin
      reject <= vote.vote_valid && !((state == OPEN) && in_range);
      unique case (state)
        IDLE: begin
          if (open_poll) begin
            for (int unsigned i = 0; i < NUM_CAND; i++) cnt[i] <= '0;
`ifdef VM_TOTAL_VOTES_EN
            total_votes <= '0;
`endif
            state <= OPEN;
          end
        end
        OPEN: begin
          if (accept) begin
            if (cnt[vote.vote_sel] != '1) cnt[vote.vote_sel] <= cnt[vote.vote_sel] + 1'b1;
`ifdef VM_TOTAL_VOTES_EN
            if (total_votes != '1) total_votes <= total_votes + 1'b1;
`endif
          end
          if (close_poll) state <= TALLY;
        end
        TALLY: begin
          if (scan_done) begin
            state        <= DONE;
            winner_valid <= 1'b1;
          end
        end
        DONE: begin
          if (open_poll) begin
            for (int unsigned i = 0; i < NUM_CAND; i++) cnt[i] <= '0;
`ifdef VM_TOTAL_VOTES_EN
            total_votes <= '0;
`endif
            winner_valid <= 1'b0;
            state        <= OPEN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  vm_tally_scan #(
    .NUM_CAND (NUM_CAND),
    .CNT_W    (CNT_W),
    .SEL_W    (SEL_W)
  ) u_scan (
    .clk    (clk),
    .reset  (reset),
    .start  (scan_start),
    .counts (counts),
    .winner (winner),
    .tie    (tie),
    .done   (scan_done)
  );

endmodule

// File: tb/tb_multi_candidate_voting_machine.sv
// Directed bench for multi_candidate_voting_machine with a behavioural poll model.
module tb_multi_candidate_voting_machine;

  localparam int N    = 5;
  localparam int CW   = 4;
  localparam int SW   = 3;
  localparam int MAXC = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic open_poll = 1'b0;
  logic close_poll = 1'b0;
  logic [N*CW-1:0] counts;
  logic [1:0]      poll_state;
  logic [SW-1:0]   winner;
  logic            winner_valid;
  logic            tie;
`ifdef VM_TOTAL_VOTES_EN
  logic [CW+SW-1:0] total_votes;
`endif

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  multi_candidate_voting_machine_if #(.SEL_W(SW)) vif ();

  multi_candidate_voting_machine #(
    .NUM_CAND (N),
    .CNT_W    (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .open_poll    (open_poll),
    .close_poll   (close_poll),
    .vote         (vif.slave),
    .counts       (counts),
    .poll_state   (poll_state),
    .winner       (winner),
    .winner_valid (winner_valid),
    .tie          (tie)
`ifdef VM_TOTAL_VOTES_EN
    ,
    .total_votes  (total_votes)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int ms;          // 0 idle, 1 open, 2 tally, 3 done
  int mcnt [N];
  int mwv, mwin, mtie, mrej, mtot, mleft;

  always @(posedge clk) begin
    if (reset) begin
      ms = 0; mwv = 0; mwin = 0; mtie = 0; mrej = 0; mtot = 0; mleft = 0;
      for (int i = 0; i < N; i++) mcnt[i] = 0;
    end else begin
      mrej = (vif.vote_valid && !(ms == 1 && int'(vif.vote_sel) < N)) ? 1 : 0;
      case (ms)
        0: if (open_poll) begin
             for (int i = 0; i < N; i++) mcnt[i] = 0;
             mtot = 0; ms = 1;
           end
        1: begin
             if (vif.vote_valid && int'(vif.vote_sel) < N) begin
               if (mcnt[vif.vote_sel] < MAXC) mcnt[vif.vote_sel]++;
               mtot++;
             end
             if (close_poll) begin ms = 2; mleft = N; end
           end
        2: begin
             mleft--;
             if (mleft == 0) begin
               int mx, nmax;
               mx = 0; nmax = 0; mwin = -1;
               for (int i = 0; i < N; i++) if (mcnt[i] > mx) mx = mcnt[i];
               for (int i = 0; i < N; i++) if (mcnt[i] == mx) begin
                 nmax++;
                 if (mwin < 0) mwin = i;
               end
               mtie = (nmax > 1) ? 1 : 0;
               mwv = 1; ms = 3;
             end
           end
        default: if (open_poll) begin
             for (int i = 0; i < N; i++) mcnt[i] = 0;
             mtot = 0; mwv = 0; ms = 1;
           end
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("poll_state", 32'(poll_state), ms);
      chk("vote_ready", 32'(vif.vote_ready), (ms == 1) ? 1 : 0);
      chk("vote_reject", 32'(vif.vote_reject), mrej);
      chk("winner_valid", 32'(winner_valid), mwv);
      for (int i = 0; i < N; i++)
        chk($sformatf("count%0d", i), 32'(counts[i*CW +: CW]), mcnt[i]);
      if (ms != 2) begin
        chk("winner", 32'(winner), mwin);
        chk("tie", 32'(tie), mtie);
      end
`ifdef VM_TOTAL_VOTES_EN
      chk("total_votes", 32'(total_votes), mtot);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input bit o, input bit c, input bit v, input int s);
    open_poll = o; close_poll = c; vif.vote_valid = v; vif.vote_sel = SW'(s);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    reset = 1'b0;
  endtask

  initial begin
    vif.vote_valid = 1'b0;
    vif.vote_sel   = '0;
    do_reset();
    chk_en = 1'b1;
    chk("lit reset state", 32'(poll_state), 0);
    chk("lit reset counts", 32'(counts), 0);
    chk("lit reset wv", 32'(winner_valid), 0);
    chk("lit reset winner", 32'(winner), 0);

    // close in IDLE is ignored
    step(0, 1, 0, 0);
    chk("lit idle close", 32'(poll_state), 0);

    // 3 votes cand 2, 1 vote cand 0
    step(1, 0, 0, 0);
    step(0, 0, 1, 2); step(0, 0, 1, 2); step(0, 0, 1, 2);
    step(0, 0, 1, 0);
    step(0, 1, 0, 0);
    idle(N - 1);
    chk("lit latency not yet done", 32'(winner_valid), 0);
    idle(1);
    chk("lit t1 state", 32'(poll_state), 3);
    chk("lit t1 c0", 32'(counts[0*CW +: CW]), 1);
    chk("lit t1 c2", 32'(counts[2*CW +: CW]), 3);
    chk("lit t1 winner", 32'(winner), 2);
    chk("lit t1 tie", 32'(tie), 0);

    // open from DONE clears; cand1 x2, cand3 x2 (last one with close)
    step(1, 0, 0, 0);
    chk("lit reopen counts", 32'(counts), 0);
    chk("lit reopen wv", 32'(winner_valid), 0);
    step(0, 0, 1, 1); step(0, 0, 1, 3); step(0, 0, 1, 1);
    step(0, 1, 1, 3);
    idle(N);
    chk("lit t2 c3", 32'(counts[3*CW +: CW]), 2);
    chk("lit t2 winner", 32'(winner), 1);
    chk("lit t2 tie", 32'(tie), 1);

    // saturation, bad index, open+close together
    step(1, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 1, 0);
    chk("lit sat c0", 32'(counts[0*CW +: CW]), 15);
    chk("lit sat no reject", 32'(vif.vote_reject), 0);
`ifdef VM_TOTAL_VOTES_EN
    chk("lit total", 32'(total_votes), 20);
`endif
    step(0, 0, 1, 5);
    chk("lit bad idx reject", 32'(vif.vote_reject), 1);
    step(0, 0, 0, 0);
    chk("lit reject one cycle", 32'(vif.vote_reject), 0);
    step(1, 1, 1, 1);
    chk("lit open+close state", 32'(poll_state), 2);
    chk("lit open+close c1", 32'(counts[1*CW +: CW]), 1);
    idle(N);
    chk("lit t3 winner", 32'(winner), 0);
    step(0, 0, 1, 2);
    chk("lit done vote reject", 32'(vif.vote_reject), 1);

    // all-zero tally
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    idle(N);
    chk("lit zero winner", 32'(winner), 0);
    chk("lit zero tie", 32'(tie), 1);

    // vote in IDLE
    do_reset();
    step(0, 0, 1, 1);
    chk("lit idle vote reject", 32'(vif.vote_reject), 1);
    chk("lit idle vote count", 32'(counts), 0);

    // reset mid-TALLY
    step(1, 0, 0, 0);
    step(0, 0, 1, 4);
    step(0, 1, 0, 0);
    idle(2);
    reset = 1'b1;
    step(0, 0, 0, 0);
    reset = 1'b0;
    chk("lit midtally state", 32'(poll_state), 0);
    chk("lit midtally counts", 32'(counts), 0);
    chk("lit midtally wv", 32'(winner_valid), 0);
    idle(N + 2);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
